// File: rtl/clock_pkg.sv
//------------------------------------------------------------------------------
// Module : clock_pkg
// Brief  : Shared mode encoding, BCD limits and blank masks for the clock.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_t;

  localparam logic [7:0] SEC_MAX_BCD = 8'h59;
  localparam logic [7:0] MIN_MAX_BCD = 8'h59;

  localparam logic [5:0] BLANK_HR  = 6'b110000;
  localparam logic [5:0] BLANK_MIN = 6'b001100;

  // Binary (0..99) to packed two-digit BCD, used for elaborating limits.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_counter.sv
//------------------------------------------------------------------------------
// Module : bcd_counter
// Brief  : Two-digit BCD counter with synchronous clear and wrap at MAX_BCD.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_counter #(
  parameter logic [7:0] MAX_BCD = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] o_q,
  output logic       carry
);

  logic [7:0] r_q;
  logic       w_at_max;

  assign w_at_max = (r_q == MAX_BCD);
  assign carry    = inc & w_at_max;
  assign o_q      = r_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= 8'h00;
    end else if (inc) begin
      if (w_at_max) begin
        r_q <= 8'h00;
      end else if (r_q[3:0] == 4'd9) begin
        r_q <= {r_q[7:4] + 4'd1, 4'd0};
      end else begin
        r_q <= {r_q[7:4], r_q[3:0] + 4'd1};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/clock_ctrl.sv
//------------------------------------------------------------------------------
// Module : clock_ctrl
// Brief  : HH:MM:SS run/set controller with blink mask and optional hourly
//          chime (enabled by defining CLOCK_CTRL_CHIME_EN).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clock_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned HOUR_MAX       = 23,
  parameter bit          SEC_CLR_ON_SET = 1'b1
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [5:0] digit_blank,
  output logic [1:0] mode,
  output logic       chime
);

  localparam logic [7:0] c_HR_MAX_BCD = to_bcd(HOUR_MAX);

  mode_t      r_mode;
  logic       r_phase;
  logic [5:0] r_blank;

  logic w_run;
  logic w_sec_inc, w_min_inc, w_hr_inc, w_sec_clr;
  logic w_sec_carry, w_min_carry;

  // In RUN the counters chain through carries; in SET modes btn_inc drives the
  // selected field alone so a wrap never ripples upward.
  assign w_run     = (r_mode == RUN);
  assign w_sec_inc = w_run & tick_1hz;
  assign w_min_inc = w_run ? w_sec_carry
                           : ((r_mode == SET_MIN) & btn_inc & ~btn_mode);
  assign w_hr_inc  = w_run ? w_min_carry
                           : ((r_mode == SET_HR) & btn_inc & ~btn_mode);
  assign w_sec_clr = SEC_CLR_ON_SET & (r_mode == SET_MIN) & btn_mode;

  bcd_counter #(.MAX_BCD(SEC_MAX_BCD)) u_sec (
    .clk   (CP),
    .rst   (CR),
    .inc   (w_sec_inc),
    .clr   (w_sec_clr),
    .o_q   (sec_bcd),
    .carry (w_sec_carry)
  );

  bcd_counter #(.MAX_BCD(MIN_MAX_BCD)) u_min (
    .clk   (CP),
    .rst   (CR),
    .inc   (w_min_inc),
    .clr   (1'b0),
    .o_q   (min_bcd),
    .carry (w_min_carry)
  );

  bcd_counter #(.MAX_BCD(c_HR_MAX_BCD)) u_hr (
    .clk   (CP),
    .rst   (CR),
    .inc   (w_hr_inc),
    .clr   (1'b0),
    .o_q   (hr_bcd),
    .carry ()
  );

  always_ff @(posedge CP) begin
    if (CR) begin
      r_mode  <= RUN;
      r_phase <= 1'b0;
      r_blank <= 6'b000000;
    end else begin
      case (r_mode)
        RUN: begin
          r_phase <= 1'b0;
          r_blank <= 6'b000000;
          if (btn_mode) r_mode <= SET_HR;
        end
        SET_HR: begin
          if (btn_mode) begin
            r_mode  <= SET_MIN;
            r_phase <= 1'b0;
            r_blank <= 6'b000000;
          end else if (btn_inc) begin
            r_phase <= 1'b0;
            r_blank <= 6'b000000;
          end else if (tick_1hz) begin
            r_phase <= ~r_phase;
            r_blank <= r_phase ? 6'b000000 : BLANK_HR;
          end
        end
        SET_MIN: begin
          if (btn_mode) begin
            r_mode  <= RUN;
            r_phase <= 1'b0;
            r_blank <= 6'b000000;
          end else if (btn_inc) begin
            r_phase <= 1'b0;
            r_blank <= 6'b000000;
          end else if (tick_1hz) begin
            r_phase <= ~r_phase;
            r_blank <= r_phase ? 6'b000000 : BLANK_MIN;
          end
        end
        default: begin
          r_mode  <= RUN;
          r_phase <= 1'b0;
          r_blank <= 6'b000000;
        end
      endcase
    end
  end

  assign mode        = r_mode;
  assign digit_blank = r_blank;

`ifdef CLOCK_CTRL_CHIME_EN
  logic r_chime;

  // A minute wrap inside RUN is exactly the tick that lands on MM:SS = 00:00.
  always_ff @(posedge CP) begin
    if (CR) begin
      r_chime <= 1'b0;
    end else begin
      r_chime <= w_run & w_min_carry;
    end
  end

  assign chime = r_chime;
`else
  assign chime = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clock_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_clock_ctrl
// Brief  : Scoreboard bench for clock_ctrl; two instances differ only in
//          whether seconds clear on leaving SET_MIN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clock_ctrl;

  logic       CP = 1'b0;
  logic       CR = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;

  logic [7:0] hr0, min0, sec0, hr1, min1, sec1;
  logic [5:0] bl0, bl1;
  logic [1:0] md0, md1;
  logic       ch0, ch1;

  always #5 CP = ~CP;

  clock_ctrl dut (
    .CP(CP), .CR(CR), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hr_bcd(hr0), .min_bcd(min0), .sec_bcd(sec0), .digit_blank(bl0),
    .mode(md0), .chime(ch0)
  );

  clock_ctrl #(.HOUR_MAX(23), .SEC_CLR_ON_SET(1'b0)) dut_nc (
    .CP(CP), .CR(CR), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hr_bcd(hr1), .min_bcd(min1), .sec_bcd(sec1), .digit_blank(bl1),
    .mode(md1), .chime(ch1)
  );

`ifdef CLOCK_CTRL_CHIME_EN
  localparam bit CHIME_EN = 1'b1;
`else
  localparam bit CHIME_EN = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [32:0] v0;
    logic [32:0] v1;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Reference model in plain decimal; index 0 clears seconds on set exit.
  int mh[2], mm[2], ms[2];
  int mmode  = 0;
  int mphase = 0;
  bit mchime[2];

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [32:0] model_vec(input int i);
    logic [5:0] blank;
    blank = 6'd0;
    if (mphase == 1 && mmode == 1) blank = 6'b110000;
    if (mphase == 1 && mmode == 2) blank = 6'b001100;
    return {bcd(mh[i]), bcd(mm[i]), bcd(ms[i]), blank, 2'(mmode), mchime[i]};
  endfunction

  task automatic model_step(input bit r, input bit t, input bit md, input bit inc);
    for (int i = 0; i < 2; i++) mchime[i] = 1'b0;
    if (r) begin
      for (int i = 0; i < 2; i++) begin mh[i] = 0; mm[i] = 0; ms[i] = 0; end
      mmode = 0; mphase = 0;
    end else if (mmode == 0) begin
      if (t) begin
        for (int i = 0; i < 2; i++) begin
          ms[i]++;
          if (ms[i] == 60) begin
            ms[i] = 0; mm[i]++;
            if (mm[i] == 60) begin
              mm[i] = 0; mchime[i] = CHIME_EN;
              mh[i] = (mh[i] == 23) ? 0 : mh[i] + 1;
            end
          end
        end
      end
      if (md) begin mmode = 1; mphase = 0; end
    end else begin
      if (md) begin
        if (mmode == 2) ms[0] = 0;
        mmode = (mmode == 1) ? 2 : 0;
        mphase = 0;
      end else if (inc) begin
        for (int i = 0; i < 2; i++) begin
          if (mmode == 1) mh[i] = (mh[i] + 1) % 24;
          else            mm[i] = (mm[i] + 1) % 60;
        end
        mphase = 0;
      end else if (t) begin
        mphase = 1 - mphase;
      end
    end
  endtask

  task automatic step(input string tag, input bit r, input bit t, input bit md, input bit inc);
    snap_t e, o;
    @(negedge CP);
    CR = r; tick_1hz = t; btn_mode = md; btn_inc = inc;
    model_step(r, t, md, inc);
    e.tag = tag; e.v0 = model_vec(0); e.v1 = model_vec(1);
    exp_q.push_back(e);
    @(posedge CP); #1;
    o.tag = tag;
    o.v0 = {hr0, min0, sec0, bl0, md0, ch0};
    o.v1 = {hr1, min1, sec1, bl1, md1, ch1};
    obs_q.push_back(o);
    CR = 1'b0; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  task automatic repeat_step(input string tag, input int n, input bit t, input bit md, input bit inc);
    for (int k = 0; k < n; k++) step(tag, 1'b0, t, md, inc);
  endtask

  task automatic test_reset();
    snap_t e, o;
    step("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    step("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat_step("reset_ticks", 3, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp += 2;
      if (o.v0 !== e.v0) begin n_err++; $display("FAIL %s clr got %h want %h", e.tag, o.v0, e.v0); end
      if (o.v1 !== e.v1) begin n_err++; $display("FAIL %s noclr got %h want %h", e.tag, o.v1, e.v1); end
    end
  endtask

  task automatic test_set_hours();
    snap_t e, o;
    step("sh_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    step("sh_mode", 1'b0, 1'b0, 1'b1, 1'b0);
    repeat_step("sh_inc", 25, 1'b0, 1'b0, 1'b1);
    repeat_step("sh_blink", 2, 1'b1, 1'b0, 1'b0);
    step("sh_tick_on", 1'b0, 1'b1, 1'b0, 1'b0);
    step("sh_inc_unblank", 1'b0, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp += 2;
      if (o.v0 !== e.v0) begin n_err++; $display("FAIL %s clr got %h want %h", e.tag, o.v0, e.v0); end
      if (o.v1 !== e.v1) begin n_err++; $display("FAIL %s noclr got %h want %h", e.tag, o.v1, e.v1); end
    end
  endtask

  task automatic test_set_minutes();
    snap_t e, o;
    step("sm_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat_step("sm_ticks", 17, 1'b1, 1'b0, 1'b0);
    repeat_step("sm_mode", 2, 1'b0, 1'b1, 1'b0);
    repeat_step("sm_inc", 61, 1'b0, 1'b0, 1'b1);
    repeat_step("sm_blink", 3, 1'b1, 1'b0, 1'b0);
    step("sm_exit", 1'b0, 1'b0, 1'b1, 1'b0);
    step("sm_run_tick", 1'b0, 1'b1, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp += 2;
      if (o.v0 !== e.v0) begin n_err++; $display("FAIL %s clr got %h want %h", e.tag, o.v0, e.v0); end
      if (o.v1 !== e.v1) begin n_err++; $display("FAIL %s noclr got %h want %h", e.tag, o.v1, e.v1); end
    end
  endtask

  task automatic test_rollover();
    snap_t e, o;
    step("ro_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat_step("ro_ticks", 59, 1'b1, 1'b0, 1'b0);
    step("ro_mode_hr", 1'b0, 1'b0, 1'b1, 1'b0);
    repeat_step("ro_inc_hr", 23, 1'b0, 1'b0, 1'b1);
    step("ro_mode_min", 1'b0, 1'b0, 1'b1, 1'b0);
    repeat_step("ro_inc_min", 59, 1'b0, 1'b0, 1'b1);
    step("ro_exit", 1'b0, 1'b0, 1'b1, 1'b0);
    step("ro_wrap", 1'b0, 1'b1, 1'b0, 1'b0);
    step("ro_after", 1'b0, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp += 2;
      if (o.v0 !== e.v0) begin n_err++; $display("FAIL %s clr got %h want %h", e.tag, o.v0, e.v0); end
      if (o.v1 !== e.v1) begin n_err++; $display("FAIL %s noclr got %h want %h", e.tag, o.v1, e.v1); end
    end
  endtask

  task automatic test_run_carry();
    snap_t e, o;
    step("rc_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat_step("rc_mode", 2, 1'b0, 1'b1, 1'b0);
    repeat_step("rc_inc", 59, 1'b0, 1'b0, 1'b1);
    step("rc_exit", 1'b0, 1'b0, 1'b1, 1'b0);
    repeat_step("rc_ticks", 61, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp += 2;
      if (o.v0 !== e.v0) begin n_err++; $display("FAIL %s clr got %h want %h", e.tag, o.v0, e.v0); end
      if (o.v1 !== e.v1) begin n_err++; $display("FAIL %s noclr got %h want %h", e.tag, o.v1, e.v1); end
    end
  endtask

  task automatic test_same_cycle();
    snap_t e, o;
    step("sc_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    step("sc_mode", 1'b0, 1'b0, 1'b1, 1'b0);
    step("sc_mode_inc_hr", 1'b0, 1'b0, 1'b1, 1'b1);
    step("sc_mode_inc_min", 1'b0, 1'b0, 1'b1, 1'b1);
    repeat_step("sc_ticks", 5, 1'b1, 1'b0, 1'b0);
    step("sc_mode_tick", 1'b0, 1'b1, 1'b1, 1'b0);
    step("sc_tick_in_set", 1'b0, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp += 2;
      if (o.v0 !== e.v0) begin n_err++; $display("FAIL %s clr got %h want %h", e.tag, o.v0, e.v0); end
      if (o.v1 !== e.v1) begin n_err++; $display("FAIL %s noclr got %h want %h", e.tag, o.v1, e.v1); end
    end
  endtask

  task automatic test_reset_mid_set();
    snap_t e, o;
    step("rm_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat_step("rm_ticks", 4, 1'b1, 1'b0, 1'b0);
    repeat_step("rm_mode", 2, 1'b0, 1'b1, 1'b0);
    repeat_step("rm_inc", 3, 1'b0, 1'b0, 1'b1);
    step("rm_blink", 1'b0, 1'b1, 1'b0, 1'b0);
    step("rm_abort", 1'b1, 1'b1, 1'b1, 1'b1);
    step("rm_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp += 2;
      if (o.v0 !== e.v0) begin n_err++; $display("FAIL %s clr got %h want %h", e.tag, o.v0, e.v0); end
      if (o.v1 !== e.v1) begin n_err++; $display("FAIL %s noclr got %h want %h", e.tag, o.v1, e.v1); end
    end
  endtask

  initial begin
    test_reset();
    test_set_hours();
    test_set_minutes();
    test_rollover();
    test_run_carry();
    test_same_cycle();
    test_reset_mid_set();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
